// File: rtl/dmx4_pkg.sv
// Shared constants and state encoding for the 1-to-4 registered demultiplexer.
package dmx4_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_st_t;

endpackage

// File: rtl/dmx4_slot.sv
// One output channel: a single-word holding register with its own
// EMPTY/FULL state and a wrapping delivered-word counter.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no word held, valid_out=0, channel can accept
// ST_FULL  | word held in data_out, valid_out=1
module dmx4_slot
  import dmx4_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [N-1:0]     data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [N-1:0]     data_out,
  output logic [CNT_W-1:0] cnt
);

  slot_st_t         r_state;
  slot_st_t         w_state_nxt;
  logic [N-1:0]     r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_dlv;

  assign w_dlv     = (r_state == ST_FULL) & ready_in;
  assign valid_out = (r_state == ST_FULL);
  assign data_out  = r_data;
  assign cnt       = r_cnt;

  // Next state: a load always leaves the slot FULL (covers drain-and-refill);
  // otherwise a delivery empties it.
  always_comb begin
    w_state_nxt = r_state;
    if (load) begin
      w_state_nxt = ST_FULL;
    end else if (w_dlv) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data register; keeps its last word after delivery.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= data_in;
    end
  end

  // Delivered-word counter, free-running wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_dlv) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmx4_reg.sv
// Registered 1-to-4 demultiplexer: one producer stream steered by in_sel
// into four independently handshaked output channels a..d.
module dmx4_reg
  import dmx4_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      a,
  output logic [N-1:0]      b,
  output logic [N-1:0]      c,
  output logic [N-1:0]      d,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic [CNT_W-1:0]  cnt_d
);

  logic              w_acc;
  logic [CH_NUM-1:0] w_load;
  logic [N-1:0]      w_data [CH_NUM];
  logic [CNT_W-1:0]  w_cnt  [CH_NUM];

  // Ready for the selected channel: empty, or draining this cycle.
  // An unknown select falls through to not-ready so X never leaks out.
  always_comb begin
    in_ready = 1'b0;
    case (in_sel)
      CH_A: in_ready = ~out_valid[CH_A] | out_ready[CH_A];
      CH_B: in_ready = ~out_valid[CH_B] | out_ready[CH_B];
      CH_C: in_ready = ~out_valid[CH_C] | out_ready[CH_C];
      CH_D: in_ready = ~out_valid[CH_D] | out_ready[CH_D];
    endcase
  end

  assign w_acc = in_valid & in_ready;

  // One-hot load decode; in_sel only matters when a word is accepted.
  always_comb begin
    w_load = '0;
    if (w_acc) begin
      case (in_sel)
        CH_A: w_load[CH_A] = 1'b1;
        CH_B: w_load[CH_B] = 1'b1;
        CH_C: w_load[CH_C] = 1'b1;
        CH_D: w_load[CH_D] = 1'b1;
      endcase
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
    dmx4_slot #(
      .N     (N),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rstn      (rstn),
      .load      (w_load[k]),
      .data_in   (in_data),
      .ready_in  (out_ready[k]),
      .valid_out (out_valid[k]),
      .data_out  (w_data[k]),
      .cnt       (w_cnt[k])
    );
  end

  assign a     = w_data[CH_A];
  assign b     = w_data[CH_B];
  assign c     = w_data[CH_C];
  assign d     = w_data[CH_D];
  assign cnt_a = w_cnt[CH_A];
  assign cnt_b = w_cnt[CH_B];
  assign cnt_c = w_cnt[CH_C];
  assign cnt_d = w_cnt[CH_D];

endmodule

// File: tb/tb_dmx4_reg.sv
// Bench for dmx4_reg: an 8-bit-counter instance and a 3-bit-counter instance
// share the same stimulus and are compared against a word-level channel model.
module tb_dmx4_reg;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic       in_valid = 1'b0;
  logic [3:0] out_ready = '0;

  logic       in_ready, ir3;
  logic [7:0] a, b, c, d, a3, b3, cc3, d3;
  logic [3:0] out_valid, ov3;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [2:0] k3a, k3b, k3c, k3d;

  int checks = 0;
  int errors = 0;

  // Model: per channel, whether a word is held, the word, deliveries so far.
  logic        m_full [4];
  logic [7:0]  m_data [4];
  int unsigned m_cnt  [4];

  always #5 clk = ~clk;

  dmx4_reg #(.N(8), .CNT_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
  );

  dmx4_reg #(.N(8), .CNT_W(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(ir3),
    .a(a3), .b(b3), .c(cc3), .d(d3),
    .out_valid(ov3), .out_ready(out_ready),
    .cnt_a(k3a), .cnt_b(k3b), .cnt_c(k3c), .cnt_d(k3d)
  );

  function automatic logic m_rdy(input logic [1:0] s, input logic [3:0] r);
    return !m_full[s] || r[s];
  endfunction

  function automatic logic [3:0] m_valid();
    return {m_full[3], m_full[2], m_full[1], m_full[0]};
  endfunction

  function automatic logic [31:0] m_dat();
    return {m_data[0], m_data[1], m_data[2], m_data[3]};
  endfunction

  function automatic logic [31:0] m_cnt8();
    return {8'(m_cnt[0]), 8'(m_cnt[1]), 8'(m_cnt[2]), 8'(m_cnt[3])};
  endfunction

  function automatic logic [11:0] m_cnt3();
    return {3'(m_cnt[0]), 3'(m_cnt[1]), 3'(m_cnt[2]), 3'(m_cnt[3])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = '0;
      m_cnt[k]  = 0;
    end
  endtask

  // Apply inputs just after an edge and let them settle.
  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] dd,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = dd;
    out_ready = r;
    #2;
  endtask

  // Advance one clock edge, update the model, sample 1 ns later.
  task automatic tick();
    logic acc;
    logic dlv;
    @(posedge clk);
    acc = 1'b0;
    if (in_valid === 1'b1) acc = m_rdy(in_sel, out_ready);
    for (int k = 0; k < 4; k++) begin
      dlv = m_full[k] && out_ready[k];
      if (dlv) m_cnt[k]++;
      if (acc && (in_sel == 2'(k))) begin
        m_full[k] = 1'b1;
        m_data[k] = in_data;
      end else if (dlv) begin
        m_full[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    checks++;
    if (out_valid !== 4'b0000 || ov3 !== 4'b0000) begin
      errors++; $display("FAIL reset_valid: got %b/%b exp 0000", out_valid, ov3);
    end
    checks++;
    if ({a, b, c, d} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {a, b, c, d});
    end
    checks++;
    if ({cnt_a, cnt_b, cnt_c, cnt_d} !== 32'h0 || {k3a, k3b, k3c, k3d} !== 12'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h exp 0", {cnt_a, cnt_b, cnt_c, cnt_d}, {k3a, k3b, k3c, k3d});
    end
    #1 rstn = 1'b1;
    tick();
    checks++;
    if (out_valid !== 4'b0000 || {a, b, c, d} !== 32'h0) begin
      errors++; $display("FAIL release_hold: got %b %h exp 0000 0", out_valid, {a, b, c, d});
    end
  endtask

  task automatic test_single_route();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'(8'h11 * (i + 1)), 4'hF);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL route_ready ch%0d: got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== (4'b0001 << i)) begin
        errors++; $display("FAIL route_valid ch%0d: got %b exp %b", i, out_valid, 4'b0001 << i);
      end
      checks++;
      if ({a, b, c, d} !== m_dat()) begin
        errors++; $display("FAIL route_data ch%0d: got %h exp %h", i, {a, b, c, d}, m_dat());
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL route_drain: got %b exp 0000", out_valid);
    end
    checks++;
    if ({cnt_a, cnt_b, cnt_c, cnt_d} !== 32'h01010101 || {cnt_a, cnt_b, cnt_c, cnt_d} !== m_cnt8()) begin
      errors++; $display("FAIL route_cnt: got %h exp 01010101", {cnt_a, cnt_b, cnt_c, cnt_d});
    end
  endtask

  task automatic test_back_to_back();
    int unsigned base;
    base = m_cnt[2];
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'd2, 8'($urandom), 4'b0100);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready cyc%0d: got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid[2] !== 1'b1 || c !== m_data[2]) begin
        errors++; $display("FAIL b2b_c cyc%0d: got v=%b c=%h exp v=1 c=%h", i, out_valid[2], c, m_data[2]);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0100);
    tick();
    checks++;
    if (cnt_c !== 8'(base + 10) || out_valid !== 4'b0000) begin
      errors++; $display("FAIL b2b_cnt: got cnt_c=%h v=%b exp cnt_c=%h v=0000", cnt_c, out_valid, 8'(base + 10));
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd1, 8'hAB, 4'b0000);
    tick();
    drive(1'b1, 2'd1, 8'hEE, 4'b0000);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_b: got %b exp 0", in_ready);
    end
    tick();
    checks++;
    if (b !== 8'hAB || out_valid[1] !== 1'b1) begin
      errors++; $display("FAIL bp_hold_b: got b=%h v=%b exp b=ab v=1", b, out_valid[1]);
    end
    drive(1'b1, 2'd3, 8'h77, 4'b0000);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_d: got %b exp 1", in_ready);
    end
    tick();
    checks++;
    if (d !== 8'h77 || out_valid !== 4'b1010) begin
      errors++; $display("FAIL bp_load_d: got d=%h v=%b exp d=77 v=1010", d, out_valid);
    end
    drive(1'b1, 2'd1, 8'hCD, 4'b0010);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_refill_ready: got %b exp 1", in_ready);
    end
    tick();
    checks++;
    if (b !== 8'hCD || out_valid !== 4'b1010 || {cnt_a, cnt_b, cnt_c, cnt_d} !== m_cnt8()) begin
      errors++; $display("FAIL bp_refill: got b=%h v=%b cnt=%h exp b=cd v=1010 cnt=%h", b, out_valid, {cnt_a, cnt_b, cnt_c, cnt_d}, m_cnt8());
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
  endtask

  task automatic test_idle_x();
    logic [3:0]  sv;
    logic [31:0] sd, sc;
    drive(1'b1, 2'd0, 8'($urandom), 4'h0);
    tick();
    drive(1'b1, 2'd2, 8'($urandom), 4'h0);
    tick();
    sv = out_valid;
    sd = {a, b, c, d};
    sc = {cnt_a, cnt_b, cnt_c, cnt_d};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'bxx, 8'hxx, 4'h0);
      tick();
      checks++;
      if (out_valid !== sv || {a, b, c, d} !== sd || {cnt_a, cnt_b, cnt_c, cnt_d} !== sc
          || out_valid !== m_valid()) begin
        errors++; $display("FAIL idle_x_state cyc%0d: got v=%b d=%h exp v=%b d=%h", i, out_valid, {a, b, c, d}, sv, sd);
      end
      checks++;
      if ($isunknown({in_ready, a, b, c, d, out_valid, cnt_a, cnt_b, cnt_c, cnt_d})) begin
        errors++; $display("FAIL idle_x_unknown cyc%0d: got rdy=%b v=%b exp no X", i, in_ready, out_valid);
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
  endtask

  task automatic test_random();
    logic       v;
    logic [1:0] s;
    logic [3:0] r;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      s = 2'($urandom);
      r = 4'($urandom);
      drive(v, s, 8'($urandom), r);
      checks++;
      if (in_ready !== m_rdy(s, r) || ir3 !== m_rdy(s, r)) begin
        errors++; $display("FAIL rand_ready cyc%0d: got %b/%b exp %b", i, in_ready, ir3, m_rdy(s, r));
      end
      tick();
      checks++;
      if (out_valid !== m_valid() || ov3 !== m_valid()) begin
        errors++; $display("FAIL rand_valid cyc%0d: got %b/%b exp %b", i, out_valid, ov3, m_valid());
      end
      checks++;
      if ({a, b, c, d} !== m_dat() || {a3, b3, cc3, d3} !== m_dat()) begin
        errors++; $display("FAIL rand_data cyc%0d: got %h exp %h", i, {a, b, c, d}, m_dat());
      end
      checks++;
      if ({cnt_a, cnt_b, cnt_c, cnt_d} !== m_cnt8() || {k3a, k3b, k3c, k3d} !== m_cnt3()) begin
        errors++; $display("FAIL rand_cnt cyc%0d: got %h/%h exp %h/%h", i, {cnt_a, cnt_b, cnt_c, cnt_d}, {k3a, k3b, k3c, k3d}, m_cnt8(), m_cnt3());
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'hF);
    tick();
  endtask

  task automatic test_wrap();
    int q[$];
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    rstn = 1'b0;
    #1 rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 2'd0, 8'($urandom), 4'b0001);
      tick();
      q.push_back(int'(k3a));
      checks++;
      if (k3a !== 3'(m_cnt[0])) begin
        errors++; $display("FAIL wrap_step cyc%0d: got %0d exp %0d", i, k3a, 3'(m_cnt[0]));
      end
    end
    drive(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    q.push_back(int'(k3a));
    checks++;
    if (q.size() != 10 || q[7] != 7 || q[8] != 0 || q[9] != 1) begin
      errors++; $display("FAIL wrap_seq: got %0d,%0d,%0d exp 7,0,1", q[7], q[8], q[9]);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd1, 8'h5A, 4'h0);
    tick();
    checks++;
    if (b !== 8'h5A || out_valid[1] !== 1'b1) begin
      errors++; $display("FAIL mid_load: got b=%h v=%b exp b=5a v=1", b, out_valid[1]);
    end
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || b !== 8'h00 || cnt_b !== 8'h00) begin
      errors++; $display("FAIL mid_async: got v=%b b=%h cnt_b=%h exp 0000 00 00", out_valid, b, cnt_b);
    end
    checks++;
    if ({a, b, c, d} !== 32'h0 || {cnt_a, cnt_b, cnt_c, cnt_d} !== 32'h0 || {k3a, k3b, k3c, k3d} !== 12'h0) begin
      errors++; $display("FAIL mid_all: got %h %h exp 0", {a, b, c, d}, {cnt_a, cnt_b, cnt_c, cnt_d});
    end
    #2 rstn = 1'b1;
    model_reset();
    tick();
    checks++;
    if (out_valid !== 4'b0000 || b !== 8'h00) begin
      errors++; $display("FAIL mid_release: got v=%b b=%h exp 0000 00", out_valid, b);
    end
  endtask

  initial begin
    test_reset();
    test_single_route();
    test_back_to_back();
    test_backpressure();
    test_idle_x();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
